// File: rtl/branch_updater.sv
// Branch-commit update queue: buffers committed branches for predictor training,
// raises a one-cycle flush with the corrected fetch PC on every accepted mispredict.
module branch_updater #(
  parameter int DEPTH    = 4,
  parameter int IDX_BITS = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     cm_valid,
  input  logic [31:0]              cm_pc,
  input  logic                     cm_pred_taken,
  input  logic                     cm_taken,
  input  logic [31:0]              cm_target,
  output logic                     cm_ready,
  output logic                     upd_right,
  output logic                     upd_wrong,
  output logic [31:0]              upd_index,
  output logic                     flush,
  output logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              mispred_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Saturating increment for the mispredict counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Each entry holds {correct, index}.
  logic [IDX_BITS:0]   r_mem [DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic                r_upd_right;
  logic                r_upd_wrong;
  logic [IDX_BITS-1:0] r_upd_index;
  logic                r_flush;
  logic [31:0]         r_redirect_pc;
  logic [15:0]         r_mispred_cnt;

  logic                w_ready;
  logic                w_push;
  logic                w_pop;
  logic                w_correct;
  logic [IDX_BITS-1:0] w_idx;
  logic [31:0]         w_redirect;
  logic [IDX_BITS:0]   w_head;

  // Handshake and entry decode.
  always_comb begin
    w_ready    = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_correct  = (cm_pred_taken == cm_taken);
    w_idx      = cm_pc[IDX_BITS+1:2];
    w_redirect = cm_pc + 32'd4;
    w_head     = r_mem[r_rptr];
    if (rdy && (r_count < CW'(DEPTH))) begin
      w_ready = 1'b1;
    end else begin
      w_ready = 1'b0;
    end
    if (cm_taken) begin
      w_redirect = cm_target;
    end else begin
      w_redirect = cm_pc + 32'd4;
    end
    // Pop decision uses the pre-edge count, so a fresh entry never bypasses.
    w_push = cm_valid && w_ready;
    w_pop  = rdy && (r_count != {CW{1'b0}});
  end

  // Entry storage; contents are don't-care outside the occupied window.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wptr] <= {w_correct, w_idx};
    end
  end

  // Pointers, occupancy, update pulses, flush and mispredict count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr        <= {PW{1'b0}};
      r_rptr        <= {PW{1'b0}};
      r_count       <= {CW{1'b0}};
      r_upd_right   <= 1'b0;
      r_upd_wrong   <= 1'b0;
      r_upd_index   <= {IDX_BITS{1'b0}};
      r_flush       <= 1'b0;
      r_redirect_pc <= 32'd0;
      r_mispred_cnt <= 16'd0;
    end else if (rdy) begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr      <= r_rptr + PW'(1);
        r_upd_index <= w_head[IDX_BITS-1:0];
      end
      r_upd_right <= w_pop && w_head[IDX_BITS];
      r_upd_wrong <= w_pop && !w_head[IDX_BITS];
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_flush <= w_push && !w_correct;
      if (w_push && !w_correct) begin
        r_redirect_pc <= w_redirect;
        r_mispred_cnt <= sat_inc16(r_mispred_cnt);
      end
    end else begin
      r_upd_right <= 1'b0;
      r_upd_wrong <= 1'b0;
      r_flush     <= 1'b0;
    end
  end

  assign cm_ready    = w_ready;
  assign upd_right   = r_upd_right;
  assign upd_wrong   = r_upd_wrong;
  assign upd_index   = {{(32-IDX_BITS){1'b0}}, r_upd_index};
  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;
  assign count       = r_count;
  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_updater.sv
// Self-checking bench for branch_updater: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_branch_updater;

  localparam int DEPTH    = 4;
  localparam int IDX_BITS = 12;

  logic        clk = 1'b0;
  logic        rst, rdy, cm_valid, cm_pred_taken, cm_taken;
  logic [31:0] cm_pc, cm_target;
  logic        cm_ready, upd_right, upd_wrong, flush;
  logic [31:0] upd_index, redirect_pc;
  logic [$clog2(DEPTH):0] count;
  logic [15:0] mispred_cnt;

  always #5 clk = ~clk;

  branch_updater #(.DEPTH(DEPTH), .IDX_BITS(IDX_BITS)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .cm_valid(cm_valid), .cm_pc(cm_pc),
    .cm_pred_taken(cm_pred_taken), .cm_taken(cm_taken), .cm_target(cm_target),
    .cm_ready(cm_ready), .upd_right(upd_right), .upd_wrong(upd_wrong),
    .upd_index(upd_index), .flush(flush), .redirect_pc(redirect_pc),
    .count(count), .mispred_cnt(mispred_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int unsigned q_idx[$];
  bit          q_ok[$];
  bit          m_right, m_wrong, m_flush, m_valid;
  logic [31:0] m_index, m_redirect;
  int unsigned m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit v, input logic [31:0] pc,
                            input bit p, input bit t, input logic [31:0] tg);
    bit push, ok, pok;
    if (r) begin
      q_idx.delete(); q_ok.delete();
      m_right = 0; m_wrong = 0; m_flush = 0;
      m_index = 32'd0; m_redirect = 32'd0; m_mis = 0; m_valid = 1;
    end else if (e) begin
      ok   = (p == t);
      push = v && (q_idx.size() < DEPTH);
      if (q_idx.size() > 0) begin
        m_index = q_idx.pop_front();
        pok     = q_ok.pop_front();
        m_right = pok; m_wrong = !pok;
      end else begin
        m_right = 0; m_wrong = 0;
      end
      if (push) begin
        q_idx.push_back((pc >> 2) % (1 << IDX_BITS));
        q_ok.push_back(ok);
        m_flush = !ok;
        if (!ok) begin
          m_redirect = t ? tg : pc + 32'd4;
          if (m_mis < 65535) m_mis++;
        end
      end else begin
        m_flush = 0;
      end
    end else begin
      m_right = 0; m_wrong = 0; m_flush = 0;
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q_idx.size()));
    chk("upd_right", 32'(upd_right), 32'(m_right));
    chk("upd_wrong", 32'(upd_wrong), 32'(m_wrong));
    chk("upd_index", upd_index, m_index);
    chk("flush", 32'(flush), 32'(m_flush));
    chk("redirect_pc", redirect_pc, m_redirect);
    chk("mispred_cnt", 32'(mispred_cnt), m_mis);
  endtask

  // One clock: drive at negedge, step model at posedge, check at next negedge.
  task automatic cyc(input bit r, input bit e, input bit v, input logic [31:0] pc,
                     input bit p, input bit t, input logic [31:0] tg);
    rst = r; rdy = e; cm_valid = v; cm_pc = pc;
    cm_pred_taken = p; cm_taken = t; cm_target = tg;
    #1;
    if (m_valid) chk("cm_ready", 32'(cm_ready), 32'(e && (q_idx.size() < DEPTH)));
    @(posedge clk);
    model_step(r, e, v, pc, p, t, tg);
    @(negedge clk);
    if (m_valid) check_all();
  endtask

  task automatic idle(input bit e);
    cyc(1'b0, e, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    bit          hv, hp, ht, r, e;
    logic [31:0] hpc, htg;
    m_valid = 0;
    rst = 1'b1; rdy = 1'b0; cm_valid = 1'b0; cm_pc = 32'd0;
    cm_pred_taken = 1'b0; cm_taken = 1'b0; cm_target = 32'd0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mis", 32'(mispred_cnt), 32'd0);

    // Correctly predicted commit.
    cyc(1'b0, 1'b1, 1'b1, 32'h1008, 1'b1, 1'b1, 32'h0);
    chk("d_corr_count", 32'(count), 32'd1);
    chk("d_corr_flush", 32'(flush), 32'd0);
    idle(1'b1);
    chk("d_corr_right", 32'(upd_right), 32'd1);
    chk("d_corr_index", upd_index, 32'h402);
    idle(1'b1);
    chk("d_corr_right_off", 32'(upd_right), 32'd0);

    // Mispredicts: taken and not-taken redirects.
    cyc(1'b0, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1, 32'h3000);
    chk("d_mis_flush", 32'(flush), 32'd1);
    chk("d_mis_redir", redirect_pc, 32'h3000);
    idle(1'b1);
    chk("d_mis_wrong", 32'(upd_wrong), 32'd1);
    chk("d_mis_flush_off", 32'(flush), 32'd0);
    chk("d_mis_cnt", 32'(mispred_cnt), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 32'h2000, 1'b1, 1'b0, 32'h3000);
    chk("d_mis_redir_nt", redirect_pc, 32'h2004);
    chk("d_mis_cnt2", 32'(mispred_cnt), 32'd2);
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
    chk("d_redir_wrap", redirect_pc, 32'h0);

    // Stall: commits offered while rdy=0 must be ignored and nothing pulses.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 32'h5000 + 32'(i * 4), 1'b0, 1'b1, 32'h6000);
      chk("d_stall_flush", 32'(flush), 32'd0);
      chk("d_stall_right", 32'(upd_right | upd_wrong), 32'd0);
    end
    idle(1'b1);

    // Ten back-to-back commits walk the pointers around the ring.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 32'h100 + 32'(i * 4), i[0], 1'b1, 32'h7000 + 32'(i));
    end
    idle(1'b1);
    idle(1'b1);

    // Reset mid-operation discards queue and pending flush.
    cyc(1'b0, 1'b1, 1'b1, 32'h8000, 1'b0, 1'b1, 32'h9000);
    cyc(1'b1, 1'b0, 1'b1, 32'h8004, 1'b0, 1'b1, 32'h9000);
    chk("d_rst_count", 32'(count), 32'd0);
    chk("d_rst_flush", 32'(flush), 32'd0);
    chk("d_rst_upd", 32'(upd_right | upd_wrong), 32'd0);
    chk("d_rst_mis", 32'(mispred_cnt), 32'd0);

    // Randomized traffic; an unaccepted commit is held by the source.
    hv = 0; hpc = 32'd0; hp = 0; ht = 0; htg = 32'd0;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 80);
      if (!hv && ($urandom_range(0, 99) < 70)) begin
        hv  = 1;
        hpc = $urandom();
        hp  = 1'($urandom());
        ht  = 1'($urandom());
        htg = $urandom();
      end
      cyc(r, e, hv, hpc, hp, ht, htg);
      if (r || e) hv = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
